median_result_writer: RTL and testbench

- Write-back end of the median filter datapath: accepts filtered pixels from Median_Filter (filt_out / filt_rdy) and writes them in raster order into the output image region of Memory.
- Uses the same memory bus as the filter's window reads (rw / addr / data / drdy), but in the write direction.
- Buffers results in a small FIFO so filter bursts do not stall on memory latency.
- Signals frame completion after all (IMG_WIDTH-WINDOW_SIZE+1) x (IMG_HEIGHT-WINDOW_SIZE+1) results are committed.

---
 rtl/median_result_writer_pkg.sv | 21 ++
 rtl/median_result_writer_fifo.sv | 58 +++++
 rtl/median_result_writer.sv | 129 ++++++++++++
 tb/tb_median_result_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_result_writer_pkg.sv
// Shared definitions for the median filter write-back path: memory bus
// commands, writer state encoding and output-image geometry.
package median_result_writer_pkg;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } wr_state_e;

    // A WIN x WIN window slid with stride 1 yields IMG-WIN+1 positions per axis.
    function automatic int out_dim(input int img, input int win);
        return img - win + 1;
    endfunction

endpackage

// File: rtl/median_result_writer_fifo.sv
// Small synchronous FIFO decoupling filter result bursts from memory latency.
// FIFO_DEPTH must be a power of two so the pointers wrap without compare logic.
module result_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_q, wr_q;
    logic [CW-1:0]         cnt_q;
    logic                  do_push, do_pop;

    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the head slot that wr_q points at.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/median_result_writer.sv
// Writes filtered pixels in raster order into the output image region of
// memory, one outstanding bus write at a time, buffered by result_fifo.
module median_result_writer
    import median_result_writer_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 8,
    parameter int IMG_WIDTH   = 7,
    parameter int IMG_HEIGHT  = 7,
    parameter int WINDOW_SIZE = 3,
    parameter int OUT_BASE    = 49,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_start,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_valid,
    output logic [1:0]            mem_rw,
    output logic [BUS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_idata,
    input  logic                  mem_drdy,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int OUT_W   = out_dim(IMG_WIDTH, WINDOW_SIZE);
    localparam int OUT_H   = out_dim(IMG_HEIGHT, WINDOW_SIZE);
    localparam int TOTAL   = OUT_W * OUT_H;
    localparam int CNT_W   = $clog2(TOTAL + 1);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    if (OUT_BASE + TOTAL > (1 << BUS_WIDTH)) begin : g_addr_range_bad
        $error("median_result_writer: OUT_BASE+TOTAL-1 exceeds BUS_WIDTH address space");
    end

    wr_state_e             state_q;
    logic [BUS_WIDTH-1:0]  wptr_q;
    logic [CNT_W-1:0]      written_q;
    logic [1:0]            mem_rw_q;
    logic [BUS_WIDTH-1:0]  mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_idata_q;
    logic                  busy_q, done_q, ovf_q;

    logic                  fifo_full, fifo_empty, fifo_room;
    logic [FIFO_CW-1:0]    fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  start, pop, push, drop;

    assign start     = wr_start && !busy_q;
    assign pop       = (state_q == ST_RUN) && !fifo_empty;
    assign fifo_room = (fifo_count < FIFO_CW'(FIFO_DEPTH));
    assign push      = res_valid && busy_q && (fifo_room || pop);
    assign drop      = res_valid && busy_q && fifo_full && !pop;

    result_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (push),
        .pop   (pop),
        .din   (res_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            written_q   <= '0;
            mem_rw_q    <= MEM_IDLE;
            mem_addr_q  <= '0;
            mem_idata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (drop) ovf_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        wptr_q    <= BUS_WIDTH'(OUT_BASE);
                        written_q <= '0;
                        done_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        mem_rw_q    <= MEM_WRITE;
                        mem_addr_q  <= wptr_q;
                        mem_idata_q <= fifo_head;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Bus outputs stay frozen until memory acknowledges.
                    if (mem_drdy) begin
                        mem_rw_q  <= MEM_IDLE;
                        wptr_q    <= wptr_q + 1'b1;
                        written_q <= written_q + 1'b1;
                        if (written_q == CNT_W'(TOTAL - 1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_idata  = mem_idata_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_median_result_writer.sv
// Randomized bench for median_result_writer: a queue-based transaction model
// predicts bus activity, flags and the sequence of committed writes.
module tb_median_result_writer;

    localparam int DW = 16, BW = 8, BASE = 49, DEPTH = 4, TOTAL = 25;

    logic          clk = 1'b0, rst = 1'b1, wr_start = 1'b0, res_valid = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic [1:0]    mem_rw;
    logic [BW-1:0] mem_addr;
    logic [DW-1:0] mem_idata;
    logic          mem_drdy = 1'b0;
    logic          busy, frame_done, overflow;

    median_result_writer dut (
        .clk(clk), .rst(rst), .wr_start(wr_start), .res_data(res_data),
        .res_valid(res_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_idata(mem_idata), .mem_drdy(mem_drdy), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [DW-1:0] mem_arr [256];
    logic [23:0]   dut_log[$];
    int            lat = 1, lcnt = 0;
    bit            spur_en = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mem_drdy = 1'b0; lcnt = 0;
        end else if (mem_drdy) begin
            mem_drdy = 1'b0; lcnt = 0;
        end else if (mem_rw == 2'b10) begin
            lcnt++;
            if (lcnt >= lat) mem_drdy = 1'b1;
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            mem_drdy = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst && mem_drdy && mem_rw == 2'b10) begin
            mem_arr[mem_addr] <= mem_idata;
            dut_log.push_back({mem_addr, mem_idata});
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] m_q[$];
    bit            m_run, m_inf, m_over, m_done;
    logic [DW-1:0] m_data;
    int            m_addr, m_written;
    logic [23:0]   exp_log[$];

    always @(posedge clk) begin
        bit was_run, pop, fin, acc;
        if (rst) begin
            m_q.delete();
            m_run = 0; m_inf = 0; m_over = 0; m_done = 0;
            m_addr = 0; m_written = 0; m_data = '0;
        end else begin
            was_run = m_run;
            pop = m_run && !m_inf && m_q.size() > 0;
            fin = m_run && m_inf && mem_drdy;
            acc = m_q.size() < DEPTH || pop;
            if (pop) begin
                m_data = m_q.pop_front();
                m_inf  = 1;
            end
            if (res_valid && was_run) begin
                if (acc) m_q.push_back(res_data);
                else     m_over = 1;
            end
            if (fin) begin
                exp_log.push_back({m_addr[7:0], m_data});
                m_addr++; m_written++; m_inf = 0;
                if (m_written == TOTAL) begin m_run = 0; m_done = 1; end
            end
            if (!was_run && wr_start) begin
                m_q.delete();
                m_run = 1; m_over = 0; m_done = 0;
                m_addr = BASE; m_written = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy, m_run);
            chk("frame_done", frame_done, m_done);
            chk("overflow", overflow, m_over);
            chk("mem_rw", mem_rw, m_inf ? 2'b10 : 2'b00);
            if (m_inf) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_idata", mem_idata, m_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        wr_start = 1'b1; cyc(1); wr_start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        res_data = d; res_valid = 1'b1; cyc(1); res_valid = 1'b0;
    endtask

    task automatic clear_logs();
        dut_log.delete(); exp_log.delete();
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'hDEAD;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
        clear_logs();
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!frame_done && n < bound) begin cyc(1); n++; end
        chk(tag, frame_done, 1'b1);
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, "_nwr"}, dut_log.size(), exp_log.size());
        for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++)
            chk({tag, "_wr"}, dut_log[i], exp_log[i]);
    endtask

    logic [DW-1:0] vals[TOTAL];

    initial begin
        clear_logs();
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_rw", mem_rw, 2'b00);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_idata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", overflow, 0);

        // Reset mid-write: slow memory, pull rst while waiting.
        lat = 30;
        pulse_start();
        send(16'h1234);
        begin
            int n = 0;
            while (mem_rw != 2'b10 && n < 10) begin cyc(1); n++; end
        end
        chk("mid_rw_wr", mem_rw, 2'b10);
        rst = 1'b1;
        #1;
        chk("mid_rst_rw", mem_rw, 2'b00);
        chk("mid_rst_busy", busy, 0);
        cyc(2); rst = 1'b0; cyc(2);
        chk("mid_rst_nowr", mem_arr[BASE], 16'hDEAD);
        chk("mid_rst_nlog", dut_log.size(), 0);

        // Single pixel latency.
        do_reset();
        lat = 1;
        pulse_start();
        send(16'h00A5);
        cyc(1);
        chk("sp_rw", mem_rw, 2'b10);
        chk("sp_addr", mem_addr, BASE);
        chk("sp_data", mem_idata, 16'h00A5);
        cyc(1);
        chk("sp_rw_idle", mem_rw, 2'b00);
        chk("sp_busy", busy, 1);
        chk("sp_mem", mem_arr[BASE], 16'h00A5);

        // Full frame, with stray drdy pulses while idle.
        do_reset();
        lat = 1; spur_en = 1'b1;
        pulse_start();
        for (int i = 0; i < TOTAL; i++) begin send(DW'(i)); cyc(4); end
        wait_done("ff_tmo", 200);
        for (int i = 0; i < TOTAL; i++) chk("ff_mem", mem_arr[BASE + i], i);
        chk("ff_busy", busy, 0);
        chk("ff_ovf", overflow, 0);
        cmp_logs("ff");
        spur_en = 1'b0;

        // Backpressure: six back-to-back results against a slow memory;
        // one is in flight and four fill the FIFO, so the sixth is dropped.
        clear_logs();
        lat = 10;
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            res_data = DW'(i); res_valid = 1'b1; cyc(1);
        end
        res_valid = 1'b0;
        cyc(70);
        chk("bp_ovf", overflow, 1);
        chk("bp_nwr", dut_log.size(), 5);
        for (int i = 0; i < 5; i++) chk("bp_mem", mem_arr[BASE + i], i + 1);
        for (int i = 0; i < TOTAL - 5; i++) begin send(DW'(16'h100 + i)); cyc(12); end
        wait_done("bp_tmo", 300);
        chk("bp_ovf_sticky", overflow, 1);
        cmp_logs("bp");

        // Ignore rules: result while DONE, wr_start mid-frame.
        clear_logs();
        lat = 2;
        send(16'hBEEF);
        cyc(3);
        chk("ig_nwr_early", dut_log.size(), 0);
        chk("ig_ovf_keep", overflow, 1);
        pulse_start();
        chk("ig_ovf_clr", overflow, 0);
        for (int i = 0; i < TOTAL; i++) begin
            vals[i] = DW'($urandom);
            send(vals[i]);
            if (i == 3) pulse_start();
            cyc(5);
        end
        wait_done("ig_tmo", 200);
        for (int i = 0; i < TOTAL; i++) chk("ig_mem", mem_arr[BASE + i], vals[i]);
        cmp_logs("ig");

        // Random frames: random latency, density and stray drdy.
        for (int f = 0; f < 3; f++) begin
            int n = 0;
            clear_logs();
            lat = $urandom_range(1, 4);
            spur_en = 1'b1;
            pulse_start();
            while (!frame_done && n < 3000) begin
                res_valid = ($urandom_range(0, 2) == 0);
                res_data  = DW'($urandom);
                cyc(1);
                n++;
            end
            res_valid = 1'b0;
            chk("rnd_tmo", frame_done, 1);
            cyc(2);
            cmp_logs("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
